// File: rtl/fila_ctrl.sv
// fila_ctrl: arbitrates two byte producers and one consumer in front of an 8-entry byte FIFO
// Ports:
//   clk_10KHz, reset (async, active-low)
//   prod0_*/prod1_*     : valid/data/ready producer handshakes, round-robin arbitrated
//   cons_req/valid/data : consumer level request, one-cycle delivery pulse, held byte
//   q_data_in/q_enqueue/q_dequeue/q_data_out/q_len : FIFO side
//   count/full/empty    : mirrored occupancy; sync_err : sticky q_len/count disagreement
module fila_ctrl #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              prod0_valid,
  input  logic [DATA_W-1:0] prod0_data,
  output logic              prod0_ready,
  input  logic              prod1_valid,
  input  logic [DATA_W-1:0] prod1_data,
  output logic              prod1_ready,
  input  logic              cons_req,
  output logic              cons_valid,
  output logic [DATA_W-1:0] cons_data,
  output logic [DATA_W-1:0] q_data_in,
  output logic              q_enqueue,
  output logic              q_dequeue,
  input  logic [DATA_W-1:0] q_data_out,
  input  logic [7:0]        q_len,
  output logic [3:0]        count,
  output logic              full,
  output logic              empty,
  output logic              sync_err
);
  typedef enum logic [1:0] {IDLE, ENQ, DEQ_ISSUE, DEQ_SHIFT} state_t;
  typedef enum logic {OP_ENQ, OP_DEQ} op_t;
  state_t            state_q, state_d;
  op_t               last_op_q, last_op_d;
  logic [3:0]        count_q, count_d;
  logic [1:0]        idle_cnt_q, idle_cnt_d;
  logic              sync_err_q, sync_err_d;
  logic              q_enqueue_q, q_enqueue_d;
  logic              q_dequeue_q, q_dequeue_d;
  logic              cons_valid_q, cons_valid_d;
  logic              rr_q, rr_d;
  logic [DATA_W-1:0] q_data_in_q, q_data_in_d;
  logic [DATA_W-1:0] cons_data_q, cons_data_d;
  logic              deq_ok, enq_ok, pick_deq, pick_enq, grant1;
  assign full     = count_q == 4'(DEPTH);
  assign empty    = count_q == 4'd0;
  assign deq_ok   = cons_req & ~empty;
  assign enq_ok   = (prod0_valid | prod1_valid) & ~full;
  // dequeue wins unless the previous operation was also a dequeue and a producer is waiting
  assign pick_deq = (state_q == IDLE) & deq_ok & ((last_op_q == OP_ENQ) | ~enq_ok);
  assign pick_enq = (state_q == IDLE) & ~pick_deq & enq_ok;
  // rr points at the preferred producer; the other one wins only when the preferred is idle
  assign grant1   = rr_q ? prod1_valid : ~prod0_valid;
  assign prod0_ready = pick_enq & ~grant1;
  assign prod1_ready = pick_enq & grant1;
  assign count      = count_q;
  assign sync_err   = sync_err_q;
  assign q_enqueue  = q_enqueue_q;
  assign q_dequeue  = q_dequeue_q;
  assign q_data_in  = q_data_in_q;
  assign cons_valid = cons_valid_q;
  assign cons_data  = cons_data_q;
  always_comb begin
    state_d      = state_q;
    last_op_d    = last_op_q;
    count_d      = count_q;
    rr_d         = rr_q;
    q_data_in_d  = q_data_in_q;
    cons_data_d  = cons_data_q;
    q_enqueue_d  = 1'b0;
    q_dequeue_d  = 1'b0;
    cons_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_deq) begin
          state_d     = DEQ_ISSUE;
          q_dequeue_d = 1'b1;
          last_op_d   = OP_DEQ;
        end else if (pick_enq) begin
          state_d     = ENQ;
          q_enqueue_d = 1'b1;
          q_data_in_d = grant1 ? prod1_data : prod0_data;
          count_d     = count_q + 4'd1;
          rr_d        = ~grant1;
          last_op_d   = OP_ENQ;
        end
      end
      ENQ:       state_d = IDLE;
      DEQ_ISSUE: state_d = DEQ_SHIFT;
      DEQ_SHIFT: begin
        state_d      = IDLE;
        cons_data_d  = q_data_out;
        cons_valid_d = 1'b1;
        count_d      = count_q - 4'd1;
      end
      default:   state_d = IDLE;
    endcase
    idle_cnt_d = (state_q == IDLE && state_d == IDLE) ? (idle_cnt_q == 2'd3 ? 2'd3 : idle_cnt_q + 2'd1) : 2'd0;
    // the FIFO's length settles a cycle or two after an operation, so only compare once idle has lasted
    sync_err_d = sync_err_q | ((state_q == IDLE) & (idle_cnt_q >= 2'd2) & (q_len != {4'd0, count_q}));
  end
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_op_q    <= OP_ENQ;
      count_q      <= 4'd0;
      idle_cnt_q   <= 2'd0;
      sync_err_q   <= 1'b0;
      q_enqueue_q  <= 1'b0;
      q_dequeue_q  <= 1'b0;
      cons_valid_q <= 1'b0;
      rr_q         <= 1'b0;
      q_data_in_q  <= '0;
      cons_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_op_q    <= last_op_d;
      count_q      <= count_d;
      idle_cnt_q   <= idle_cnt_d;
      sync_err_q   <= sync_err_d;
      q_enqueue_q  <= q_enqueue_d;
      q_dequeue_q  <= q_dequeue_d;
      cons_valid_q <= cons_valid_d;
      rr_q         <= rr_d;
      q_data_in_q  <= q_data_in_d;
      cons_data_q  <= cons_data_d;
    end
  end
endmodule

// File: tb/tb_fila_ctrl.sv
// tb_fila_ctrl: scripted vectors, corner sequences and randomized traffic against a reference model
module tb_fila_ctrl;
  logic       clk_10KHz = 1'b0;
  logic       reset = 1'b0;
  logic       prod0_valid = 1'b0, prod1_valid = 1'b0, cons_req = 1'b0;
  logic [7:0] prod0_data = '0, prod1_data = '0;
  logic       prod0_ready, prod1_ready, cons_valid, q_enqueue, q_dequeue, full, empty, sync_err;
  logic [7:0] cons_data, q_data_in;
  logic [7:0] q_data_out = '0, q_len = '0;
  logic [3:0] count;
  int checks = 0, errors = 0;
  always #5 clk_10KHz = ~clk_10KHz;
  fila_ctrl #(.DEPTH(8), .DATA_W(8)) dut (
    .clk_10KHz(clk_10KHz), .reset(reset),
    .prod0_valid(prod0_valid), .prod0_data(prod0_data), .prod0_ready(prod0_ready),
    .prod1_valid(prod1_valid), .prod1_data(prod1_data), .prod1_ready(prod1_ready),
    .cons_req(cons_req), .cons_valid(cons_valid), .cons_data(cons_data),
    .q_data_in(q_data_in), .q_enqueue(q_enqueue), .q_dequeue(q_dequeue),
    .q_data_out(q_data_out), .q_len(q_len),
    .count(count), .full(full), .empty(empty), .sync_err(sync_err)
  );
  // FIFO stand-in: enqueue writes on the edge, dequeue latches head then shifts on the next edge
  logic [7:0] fq[$];
  bit         fpend;
  int         bad_len;
  // reference model: bytes accepted but not yet delivered, plus remaining cycles of the current operation
  logic [7:0] mq[$];
  int         busy;
  bit         mdeq, mlast_deq, mrr, m_cv;
  logic [7:0] m_din, m_cd;
  typedef struct {
    bit p0v; logic [7:0] p0d; bit p1v; logic [7:0] p1d; bit creq;
    bit p0r; bit p1r; bit qe; bit qd; bit cv; logic [7:0] cd; logic [7:0] qdin; int cnt;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // 0 none, 1 enqueue from producer 0, 2 enqueue from producer 1, 3 dequeue
  function automatic int decide();
    bit deq_ok, enq_ok;
    if (busy != 0) return 0;
    deq_ok = cons_req && mq.size() != 0;
    enq_ok = (prod0_valid || prod1_valid) && mq.size() < 8;
    if (deq_ok && (!mlast_deq || !enq_ok)) return 3;
    if (!enq_ok) return 0;
    if (!mrr) return prod0_valid ? 1 : 2;
    return prod1_valid ? 2 : 1;
  endfunction
  task automatic clear_models();
    fq.delete(); fpend = 0; bad_len = 0; q_data_out = '0; q_len = '0;
    mq.delete(); busy = 0; mdeq = 0; mlast_deq = 0; mrr = 0; m_cv = 0; m_din = '0; m_cd = '0;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    prod0_valid = 0; prod1_valid = 0; cons_req = 0;
    clear_models();
    repeat (2) @(posedge clk_10KHz);
    @(negedge clk_10KHz) reset = 1'b1;
  endtask
  task automatic tick();
    int d = decide();
    logic qe = q_enqueue, qd = q_dequeue;
    logic [7:0] qdi = q_data_in, a_d = prod0_data, b_d = prod1_data;
    @(posedge clk_10KHz);
    #1;
    chk("enq_deq_overlap", {31'd0, qe && qd}, 0);
    if (qe) fq.push_back(qdi);
    if (qd && fq.size() > 0) begin q_data_out = fq[0]; fpend = 1; end
    else if (fpend) begin void'(fq.pop_front()); fpend = 0; end
    chk("fifo_overflow", {31'd0, fq.size() > 8}, 0);
    q_len = 8'(fq.size() + bad_len);
    m_cv = 0;
    if (busy != 0) begin
      busy--;
      if (busy == 0 && mdeq) begin m_cd = mq.pop_front(); m_cv = 1; end
    end else if (d == 3) begin
      busy = 2; mdeq = 1; mlast_deq = 1;
    end else if (d != 0) begin
      m_din = (d == 1) ? a_d : b_d;
      mq.push_back(m_din);
      mrr = (d == 1); mlast_deq = 0; busy = 1; mdeq = 0;
    end
  endtask
  task automatic check_model();
    int d = decide();
    chk("prod0_ready", prod0_ready, d == 1);
    chk("prod1_ready", prod1_ready, d == 2);
    chk("q_enqueue", q_enqueue, busy == 1 && !mdeq);
    chk("q_dequeue", q_dequeue, busy == 2);
    chk("q_data_in", q_data_in, m_din);
    chk("cons_valid", cons_valid, m_cv);
    chk("cons_data", cons_data, m_cd);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == 8);
    chk("empty", empty, mq.size() == 0);
    chk("sync_err", sync_err, 0);
  endtask
  task automatic cycle(input bit a, input logic [7:0] ad, input bit b, input logic [7:0] bd, input bit c);
    @(negedge clk_10KHz);
    prod0_valid = a; prod0_data = ad; prod1_valid = b; prod1_data = bd; cons_req = c;
    #1 check_model();
    tick();
  endtask
  initial begin
    #300000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{1, 8'hA5, 0, 8'h00, 0,  1, 0, 0, 0, 0, 8'h00, 8'h00, 0};
    tbl[1]  = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 8'h00, 8'hA5, 1};
    tbl[2]  = '{1, 8'h11, 1, 8'h22, 0,  0, 1, 0, 0, 0, 8'h00, 8'hA5, 1};
    tbl[3]  = '{1, 8'h11, 1, 8'h22, 0,  0, 0, 1, 0, 0, 8'h00, 8'h22, 2};
    tbl[4]  = '{1, 8'h11, 1, 8'h22, 1,  0, 0, 0, 0, 0, 8'h00, 8'h22, 2};
    tbl[5]  = '{1, 8'h11, 1, 8'h22, 1,  0, 0, 0, 1, 0, 8'h00, 8'h22, 2};
    tbl[6]  = '{1, 8'h11, 1, 8'h22, 1,  0, 0, 0, 0, 0, 8'h00, 8'h22, 2};
    tbl[7]  = '{1, 8'h11, 1, 8'h22, 1,  1, 0, 0, 0, 1, 8'hA5, 8'h22, 1};
    tbl[8]  = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 1, 0, 0, 8'hA5, 8'h11, 2};
    tbl[9]  = '{0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 0, 8'hA5, 8'h11, 2};
    tbl[10] = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 1, 0, 8'hA5, 8'h11, 2};
    tbl[11] = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 0, 0, 8'hA5, 8'h11, 2};
    tbl[12] = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 0, 1, 8'h22, 8'h11, 1};
    tbl[13] = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 0, 0, 8'h22, 8'h11, 1};
    do_reset();
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_cons_valid", cons_valid, 0);
    chk("rst_q_data_in", q_data_in, 0);
    chk("rst_sync_err", sync_err, 0);
    // scripted vectors: enqueue, round-robin, dequeue priority, cons_req dropped mid-sequence
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_10KHz);
      prod0_valid = tbl[i].p0v; prod0_data = tbl[i].p0d;
      prod1_valid = tbl[i].p1v; prod1_data = tbl[i].p1d; cons_req = tbl[i].creq;
      #1;
      chk($sformatf("v%0d_p0r", i), prod0_ready, tbl[i].p0r);
      chk($sformatf("v%0d_p1r", i), prod1_ready, tbl[i].p1r);
      chk($sformatf("v%0d_qenq", i), q_enqueue, tbl[i].qe);
      chk($sformatf("v%0d_qdeq", i), q_dequeue, tbl[i].qd);
      chk($sformatf("v%0d_cv", i), cons_valid, tbl[i].cv);
      chk($sformatf("v%0d_cd", i), cons_data, tbl[i].cd);
      chk($sformatf("v%0d_qdin", i), q_data_in, tbl[i].qdin);
      chk($sformatf("v%0d_cnt", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_serr", i), sync_err, 0);
      tick();
    end
    // fill from empty with both producers streaming
    do_reset();
    repeat (16) cycle(1, 8'h11, 1, 8'h22, 0);
    @(negedge clk_10KHz);
    #1;
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_p0_ready", prod0_ready, 0);
    chk("fill_p1_ready", prod1_ready, 0);
    chk("fill_len", fq.size(), 8);
    for (int i = 0; i < 8 && i < fq.size(); i++) chk($sformatf("fill_order%0d", i), fq[i], (i % 2) ? 8'h22 : 8'h11);
    // full FIFO with producer and consumer both held: strict alternation
    for (int i = 0; i < 24; i++) begin
      cycle(1, 8'($urandom), 0, 8'h00, 1);
      chk("alt_count_range", {31'd0, count >= 7 && count <= 8}, 1);
    end
    // reset asserted while in DEQ_SHIFT
    for (int n = 0; n < 12 && !q_dequeue; n++) cycle(0, 8'h00, 0, 8'h00, 1);
    chk("deq_issue_seen", q_dequeue, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    @(negedge clk_10KHz);
    chk("shift_qdeq_low", q_dequeue, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_cv", cons_valid, 0);
    chk("mid_rst_cd", cons_data, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_qenq", q_enqueue, 0);
    chk("mid_rst_qdeq", q_dequeue, 0);
    chk("mid_rst_qdin", q_data_in, 0);
    do_reset();
    #1;
    chk("post_rst_cv", cons_valid, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_serr", sync_err, 0);
    repeat (3) cycle(0, 8'h00, 0, 8'h00, 0);
    // randomized traffic with phases that lean towards filling or draining
    for (int i = 0; i < 800; i++) begin
      bit fill = ((i / 100) % 2) == 0;
      cycle($urandom_range(0, 3) < (fill ? 3 : 1), 8'($urandom),
            $urandom_range(0, 3) < (fill ? 2 : 1), 8'($urandom),
            $urandom_range(0, 3) < (fill ? 1 : 3));
    end
    // sticky sync error from a disagreeing q_len
    do_reset();
    bad_len = 1; q_len = 8'd1;
    tick();
    @(negedge clk_10KHz);
    chk("serr_early", sync_err, 0);
    repeat (4) tick();
    @(negedge clk_10KHz);
    chk("serr_set", sync_err, 1);
    bad_len = 0; q_len = 8'd0;
    repeat (3) tick();
    @(negedge clk_10KHz);
    chk("serr_sticky", sync_err, 1);
    do_reset();
    #1;
    chk("serr_cleared", sync_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fila_ctrl.md
Name: fila_ctrl

Overview:
- Scheduler and sequencer in front of the 8-entry byte FIFO (fila).
- Arbitrates two byte producers for the FIFO's single enqueue port and serves one consumer through the FIFO's two-cycle dequeue protocol.
- Mirrors FIFO occupancy so no illegal enqueue/dequeue combination ever reaches the FIFO.
- Sits between the producer/consumer logic and the FIFO instance in the top level.

Parameters:
- DEPTH, 8, FIFO capacity in entries.
- DATA_W, 8, data width in bits.

Ports:
- clk_10KHz  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- prod0_valid  in  1  producer 0 has a byte.
- prod0_data  in  DATA_W  producer 0 byte.
- prod0_ready  out  1  producer 0 byte accepted this edge when valid&ready.
- prod1_valid  in  1  producer 1 has a byte.
- prod1_data  in  DATA_W  producer 1 byte.
- prod1_ready  out  1  producer 1 byte accepted this edge when valid&ready.
- cons_req  in  1  consumer wants one byte, level.
- cons_valid  out  1  one-cycle pulse, cons_data valid.
- cons_data  out  DATA_W  dequeued byte, held until next delivery.
- q_data_in  out  DATA_W  to FIFO data_in.
- q_enqueue  out  1  to FIFO enqueue_in.
- q_dequeue  out  1  to FIFO dequeue_in.
- q_data_out  in  DATA_W  from FIFO data_out.
- q_len  in  8  from FIFO len_out.
- count  out  4  mirrored occupancy, 0..DEPTH.
- full  out  1  count==DEPTH, combinational.
- empty  out  1  count==0, combinational.
- sync_err  out  1  sticky: q_len disagreed with count.

Behaviour:
- Reset (reset=0, async) values:
  - FSM=IDLE, count=0, sync_err=0.
  - q_enqueue=0, q_dequeue=0, q_data_in=0.
  - cons_valid=0, cons_data=0.
  - rr pointer=producer 0, last_op=ENQ, idle_cnt=0.
- FIFO reset comes from the same source, inverted at top level.
- Reset mid-sequence aborts the sequence; no cons_valid is issued.
- FSM states: IDLE, ENQ, DEQ_ISSUE, DEQ_SHIFT. All q_* outputs and cons_* outputs are registered.
- IDLE decision, combinational each cycle:
  - deq_ok = cons_req & !empty.
  - enq_ok = (prod0_valid | prod1_valid) & !full.
  - Pick dequeue if deq_ok and (last_op==ENQ or !enq_ok).
  - Else pick enqueue if enq_ok.
  - Else stay in IDLE.
- Producer grant: round-robin.
  - The producer pointed to by rr wins if valid; otherwise the other one wins.
  - prodX_ready=1 only in IDLE for the granted producer when enqueue is picked. It is 0 in every other state.
- Enqueue edge (IDLE -> ENQ):
  - q_data_in <= granted data, q_enqueue <= 1, count <= count+1.
  - rr <= other producer, last_op <= ENQ.
- ENQ (1 cycle): FIFO writes at the end edge; q_enqueue <= 0; -> IDLE. Throughput is at most one byte per 2 cycles.
- Dequeue edge (IDLE -> DEQ_ISSUE): q_dequeue <= 1, last_op <= DEQ.
- DEQ_ISSUE (1 cycle): q_dequeue=1; FIFO latches its head at the end edge; q_dequeue <= 0; -> DEQ_SHIFT.
- DEQ_SHIFT (1 cycle):
  - q_dequeue=0 (mandatory, so the FIFO shifts) and q_enqueue=0.
  - End edge: cons_data <= q_data_out, cons_valid <= 1, count <= count-1; -> IDLE.
- Dequeue latency: cons_valid is high in the 3rd cycle after the IDLE decision cycle.
- cons_valid is cleared on the following edge.
- If cons_req drops mid-sequence, the sequence still completes and delivers.
- q_enqueue and q_dequeue are never both 1. No enqueue is ever issued in DEQ_ISSUE or DEQ_SHIFT.
- full: prodX_ready stays 0; no overflow is possible. Dequeue is still served.
- empty: cons_req is ignored; q_dequeue stays 0.
- Consistency check:
  - idle_cnt counts consecutive IDLE cycles, saturating at 3; it resets to 0 on leaving IDLE.
  - When idle_cnt>=2 and q_len!=count, set sync_err=1; it is cleared only by reset.

Test Plan:
- Reset, then prod0 sends 0xA5 -> prod0_ready pulse; q_enqueue high for 1 cycle with q_data_in=0xA5; count=1; q_len=1 two cycles later; sync_err stays 0.
- Both producers valid continuously (prod0=0x11, prod1=0x22), no consumer -> grants alternate 0,1,0,1…; 8 bytes enqueued in 16 cycles; full=1 and both ready=0 afterwards; count=8.
- FIFO holds 0x11,0x22,0x33; hold cons_req -> cons_valid pulses with cons_data 0x11, 0x22, 0x33, each 3 cycles after its decision; empty=1 and count=0 at end; q_dequeue never high two cycles in a row.
- FIFO full (8 bytes), prod0 valid and cons_req both held -> strict alternation of dequeue and enqueue; count oscillates 8↔7; delivered bytes are in FIFO order; q_enqueue is never high in a DEQ_SHIFT cycle.
- cons_req pulsed for 1 cycle with count=2 -> exactly one cons_valid delivering the head byte; count=1.
- reset asserted during DEQ_SHIFT -> cons_valid stays 0; all outputs at reset values; count=0; sync_err=0 after release.
